// File: rtl/btb_ctrl.sv
// btb_ctrl: sole write port of the branch target buffer; sweeps the array to zero after reset
// or flush, then turns EX-stage branch outcomes into single entry writes.
module btb_ctrl #(
   parameter  int DEPTH = 512,
   parameter  int IDX_W = 9,
   parameter  int TAG_W = 7,
   parameter  int TGT_W = 16,
   localparam int W     = TAG_W + 2 + TGT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_req,
   input  logic             upd_alloc,
   input  logic             upd_evict,
   input  logic             upd_confirm,
   input  logic             upd_strong,
   input  logic [IDX_W-1:0] upd_index,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic [TGT_W-1:0] upd_target,
   output logic             mem_we,
   output logic [IDX_W-1:0] mem_waddr,
   output logic [W-1:0]     mem_wdata,
   output logic             btb_en,
   output logic             busy,
   output logic             flush_done,
   output logic [7:0]       drop_cnt
);
   typedef enum logic [1:0] {INIT, FLUSH, READY} state_t;
   state_t           state, state_nx;
   logic [IDX_W:0]   cnt, cnt_nx;
   logic             we_nx, busy_nx, done_nx, any_upd, promote;
   logic [IDX_W-1:0] waddr_nx;
   logic [W-1:0]     wdata_nx, upd_word;
   logic [7:0]       drop_nx;
   assign any_upd  = upd_alloc | upd_evict | upd_confirm;
   assign promote  = upd_confirm & ~upd_evict & ~upd_alloc;
   assign upd_word = {upd_tag, promote, 1'b1, upd_target};
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      we_nx    = 1'b0;
      waddr_nx = '0;
      wdata_nx = '0;
      busy_nx  = busy;
      done_nx  = 1'b0;
      drop_nx  = drop_cnt;
      if (state == READY) begin
         we_nx    = upd_evict | upd_alloc | (upd_confirm & ~upd_strong);
         waddr_nx = we_nx ? upd_index : '0;
         // a weak entry that mispredicts is invalidated rather than demoted
         wdata_nx = (!we_nx || (upd_evict && !upd_strong)) ? '0 : upd_word;
         if (flush_req) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
            busy_nx  = 1'b1;
         end
      end else begin
         drop_nx = (any_upd && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
         if (flush_req) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
         end else if (cnt == (IDX_W+1)'(DEPTH)) begin
            state_nx = READY;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
         end else begin
            we_nx    = 1'b1;
            waddr_nx = cnt[IDX_W-1:0];
            cnt_nx   = cnt + (IDX_W+1)'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= INIT;
         cnt        <= '0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         btb_en     <= 1'b0;
         busy       <= 1'b1;
         flush_done <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         mem_we     <= we_nx;
         mem_waddr  <= waddr_nx;
         mem_wdata  <= wdata_nx;
         btb_en     <= ~busy_nx;
         busy       <= busy_nx;
         flush_done <= done_nx;
         drop_cnt   <= drop_nx;
      end
   end
endmodule

// File: tb/tb_btb_ctrl.sv
// tb_btb_ctrl: directed bench for btb_ctrl with a cycle model of the sweep/update rules
// and a shadow copy of the BTB array built from the observed writes.
module tb_btb_ctrl;
   localparam int DEPTH = 512;
   localparam int W     = 25;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_req = 1'b0, upd_alloc = 1'b0, upd_evict = 1'b0, upd_confirm = 1'b0, upd_strong = 1'b0;
   logic [8:0]    upd_index = '0;
   logic [6:0]    upd_tag = '0;
   logic [15:0]   upd_target = '0;
   logic          mem_we, btb_en, busy, flush_done;
   logic [8:0]    mem_waddr;
   logic [W-1:0]  mem_wdata;
   logic [7:0]    drop_cnt;
   int            errs = 0, checks = 0;
   btb_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .upd_alloc(upd_alloc), .upd_evict(upd_evict),
      .upd_confirm(upd_confirm), .upd_strong(upd_strong), .upd_index(upd_index), .upd_tag(upd_tag),
      .upd_target(upd_target), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .btb_en(btb_en), .busy(busy), .flush_done(flush_done), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // model: sweeping flag plus next index to clear; expected outputs per edge
   bit          m_sweep = 1'b1;
   int          m_pos = 0, m_drop = 0, e_addr = 0;
   bit          e_we = 1'b0, e_busy = 1'b1, e_en = 1'b0, e_done = 1'b0;
   logic [31:0] e_data = '0;
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_sweep = 1'b1; m_pos = 0; m_drop = 0;
         e_we = 1'b0; e_addr = 0; e_data = '0; e_done = 1'b0;
      end else begin
         int field;
         field = int'(upd_tag) * 262144 + 65536 + int'(upd_target);
         e_we = 1'b0; e_addr = 0; e_data = '0; e_done = 1'b0;
         if (m_sweep) begin
            if (upd_alloc || upd_evict || upd_confirm) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            if (flush_req) m_pos = 0;
            else if (m_pos == DEPTH) begin m_sweep = 1'b0; e_done = 1'b1; end
            else begin e_we = 1'b1; e_addr = m_pos; m_pos++; end
         end else begin
            e_addr = int'(upd_index);
            if (upd_evict) begin e_we = 1'b1; e_data = upd_strong ? field : 0; end
            else if (upd_alloc) begin e_we = 1'b1; e_data = field; end
            else if (upd_confirm && !upd_strong) begin e_we = 1'b1; e_data = field + 131072; end
            if (flush_req) begin m_sweep = 1'b1; m_pos = 0; end
         end
      end
      e_busy = m_sweep;
      e_en   = !m_sweep;
   end
   initial forever begin
      @(negedge clk);
      chk("we", mem_we, e_we);
      chk("busy", busy, e_busy);
      chk("btb_en", btb_en, e_en);
      chk("flush_done", flush_done, e_done);
      chk("drop_cnt", drop_cnt, m_drop);
      if (e_we) begin
         chk("waddr", mem_waddr, e_addr);
         chk("wdata", mem_wdata, e_data);
      end
   end
   logic [W-1:0] shadow [DEPTH] = '{default: 25'h1ABCDE};
   initial forever begin
      @(negedge clk);
      if (mem_we === 1'b1) shadow[mem_waddr] = mem_wdata;
   end
   function automatic int nonzero();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (shadow[i] !== '0) n++;
      return n;
   endfunction
   task automatic run_sweep(input int limit, output int writes);
      int dones = 0;
      writes = 0;
      for (int i = 0; i < limit && dones == 0; i++) begin
         @(negedge clk);
         writes += int'(mem_we);
         dones  += int'(flush_done);
      end
      chk("sweep_done_seen", dones, 1);
   endtask
   task automatic wait_addr(input int a);
      bit found = 1'b0;
      int dones = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         dones += int'(flush_done);
         found = mem_we && mem_waddr == 9'(a);
      end
      chk("reach_sweep_index", found, 1);
      chk("no_done_midsweep", dones, 0);
   endtask
   task automatic upd(input bit a, e, c, s, input int idx, tag, tgt);
      upd_alloc = a; upd_evict = e; upd_confirm = c; upd_strong = s;
      upd_index = 9'(idx); upd_tag = 7'(tag); upd_target = 16'(tgt);
      @(negedge clk);
      upd_alloc = 1'b0; upd_evict = 1'b0; upd_confirm = 1'b0; upd_strong = 1'b0;
   endtask
   initial begin
      int w, n;
      repeat (2) @(negedge clk);
      chk("rst_we", mem_we, 0);
      chk("rst_busy", busy, 1);
      chk("rst_en", btb_en, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      upd_alloc = 1'b1; upd_index = 9'h05; upd_tag = 7'h12; upd_target = 16'hBEEF;
      w = 0;
      repeat (3) begin @(negedge clk); w += int'(mem_we); end
      upd_alloc = 1'b0;
      chk("init_first_addrs", mem_waddr, 2);
      chk("init_drop3", drop_cnt, 3);
      run_sweep(600, n);
      chk("init_writes", w + n, 512);
      chk("ready_busy", busy, 0);
      chk("ready_en", btb_en, 1);
      chk("init_all_zero", nonzero(), 0);
      upd(1, 0, 0, 0, 'h05, 'h12, 'hBEEF);
      chk("alloc_we", mem_we, 1);
      chk("alloc_addr", mem_waddr, 5);
      chk("alloc_data", mem_wdata, 25'h49BEEF);
      upd(0, 1, 0, 1, 'h05, 'h12, 'hBEEF);
      chk("demote_data", mem_wdata, 25'h49BEEF);
      upd(0, 1, 0, 0, 'h05, 'h12, 'hBEEF);
      chk("inval_we", mem_we, 1);
      chk("inval_data", mem_wdata, 0);
      upd(0, 0, 1, 0, 'h05, 'h12, 'hBEEF);
      chk("promote_data", mem_wdata, 25'h4BBEEF);
      upd(0, 0, 1, 1, 'h05, 'h12, 'hBEEF);
      chk("confirm_strong_nowrite", mem_we, 0);
      upd(1, 1, 1, 0, 'h07, 'h33, 'h4444);
      chk("prio_evict_addr", mem_waddr, 7);
      chk("prio_evict_data", mem_wdata, 0);
      upd(1, 0, 1, 0, 'h09, 'h7F, 'h1234);
      chk("prio_alloc_data", mem_wdata, 25'h1FD1234);
      upd(0, 0, 0, 0, 'h1FF, 'h7F, 'hFFFF);
      chk("idle_nowrite", mem_we, 0);
      flush_req = 1'b1;
      upd(1, 0, 0, 0, 'h03, 'h01, 'h00FF);
      flush_req = 1'b0;
      chk("flush_edge_write", mem_wdata, 25'h500FF);
      chk("flush_edge_busy", busy, 1);
      chk("flush_edge_en", btb_en, 0);
      @(negedge clk);
      chk("flush_first_addr", mem_waddr, 0);
      wait_addr(300);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      chk("abort_nowrite", mem_we, 0);
      run_sweep(600, n);
      chk("restart_writes", n, 512);
      repeat (3) @(negedge clk);
      chk("flush_all_zero", nonzero(), 0);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      upd_confirm = 1'b1;
      w = 0;
      repeat (300) begin @(negedge clk); w += int'(mem_we); end
      upd_confirm = 1'b0;
      chk("drop_saturate", drop_cnt, 255);
      run_sweep(600, n);
      chk("sat_sweep_writes", w + n, 512);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      wait_addr(100);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_we", mem_we, 0);
      chk("midrst_busy", busy, 1);
      chk("midrst_drop", drop_cnt, 0);
      chk("midrst_waddr", mem_waddr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rerun_first_addr", mem_waddr, 0);
      chk("rerun_first_we", mem_we, 1);
      run_sweep(600, n);
      chk("rerun_writes", n + 1, 512);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
      $fatal(1, "timeout");
   end
endmodule
